// File: rtl/speed_selector.sv
`default_nettype none
// ============================================================================
// Module   : speed_selector
// Purpose  : Debounced up/down buttons -> saturating speed level 1..6, plus a
//            step pulse whose rate scales with the level.
// Revision : 1.0
// ============================================================================
module speed_selector #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_BASE       = 600000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       enable,
  output logic [2:0] digit,
  output logic       step_tick,
  output logic       level_changed
);

  localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       c_lvl_min = 3'd1;
  localparam logic [2:0]       c_lvl_max = 3'd6;

  logic [1:0] w_btn_raw;
  logic [1:0] w_press;

  assign w_btn_raw = {btn_down, btn_up};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d, deb_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only survives while the sample keeps disagreeing with the state.
    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == c_db_last) begin
          deb_d = ~deb_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= w_btn_raw[gi];
        sync2_q    <= sync1_q;
        deb_q      <= deb_d;
        deb_prev_q <= deb_q;
        cnt_q      <= cnt_d;
      end
    end

    assign w_press[gi] = deb_q & ~deb_prev_q;
  end

  logic [2:0]       digit_q, digit_d;
  logic             w_change;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [CNT_W-1:0] w_period_last;
  logic             step_tick_q, step_tick_d;
  logic             level_changed_q;

  always_comb begin
    digit_d = digit_q;
    if (w_press[0] && !w_press[1] && (digit_q < c_lvl_max)) begin
      digit_d = digit_q + 3'd1;
    end else if (w_press[1] && !w_press[0] && (digit_q > c_lvl_min)) begin
      digit_d = digit_q - 3'd1;
    end
  end

  assign w_change = (digit_d != digit_q);

  always_comb begin
    case (digit_q)
      3'd2:    w_period_last = CNT_W'(STEP_BASE / 2 - 1);
      3'd3:    w_period_last = CNT_W'(STEP_BASE / 3 - 1);
      3'd4:    w_period_last = CNT_W'(STEP_BASE / 4 - 1);
      3'd5:    w_period_last = CNT_W'(STEP_BASE / 5 - 1);
      3'd6:    w_period_last = CNT_W'(STEP_BASE / 6 - 1);
      default: w_period_last = CNT_W'(STEP_BASE - 1);
    endcase
  end

  // A level change restarts the period and swallows a tick due on that edge.
  always_comb begin
    step_cnt_d  = '0;
    step_tick_d = 1'b0;
    if (enable && !w_change) begin
      if (step_cnt_q >= w_period_last) begin
        step_tick_d = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q         <= c_lvl_min;
      level_changed_q <= 1'b0;
      step_cnt_q      <= '0;
      step_tick_q     <= 1'b0;
    end else begin
      digit_q         <= digit_d;
      level_changed_q <= w_change;
      step_cnt_q      <= step_cnt_d;
      step_tick_q     <= step_tick_d;
    end
  end

  assign digit         = digit_q;
  assign step_tick     = step_tick_q;
  assign level_changed = level_changed_q;

endmodule
`default_nettype wire
